restoring_divider_by8: RTL and testbench
========================================

Name: restoring_divider_by8

Overview:
- Multi-cycle unsigned restoring divider for the ALU datapath, built on repeated trial subtraction (the inverse of the ripple adder chain).
- Produces quotient and remainder of two DATA_WIDTH operands, one quotient bit per cycle.
- Uses a start/busy/done handshake, so the ALU control FSM issues a divide and waits for done.
- Sits beside the adder in the ALU execute stage; results are muxed onto the ALU result bus by the control logic.

Parameters:
- DATA_WIDTH, 8, operand/result width; default matches CPU_package DATA_WIDTH, must be >= 2.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a divide; sampled only when ready=1.
- dividend, input, DATA_WIDTH, unsigned numerator; sampled on the accepting edge.
- divisor, input, DATA_WIDTH, unsigned denominator; sampled on the accepting edge.
- ready, output, 1, 1 in IDLE and DONE (start will be accepted).
- busy, output, 1, 1 while iterating.
- done, output, 1, one-cycle pulse; results valid.
- quotient, output, DATA_WIDTH, registered quotient, held until next accept.
- remainder, output, DATA_WIDTH, registered remainder, held until next accept.
- div_by_zero, output, 1, set with done when divisor was 0; held with results.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0, ready=1.
  - Reset mid-operation aborts the divide; no done is produced.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 at an edge is an accept.
    - Latch divisor; load shift register with dividend; partial remainder R=0; iteration counter=0.
    - If divisor==0, go to DONE; otherwise go to BUSY.
  - BUSY: one iteration per edge, for exactly DATA_WIDTH edges.
    - R' = {R[DATA_WIDTH-1:0], msb of shift reg}, DATA_WIDTH+1 bits wide.
    - T = R' - divisor, DATA_WIDTH+1 bits.
    - If T has no borrow (msb 0), R=T and quotient bit=1; else R=R' (restore) and quotient bit=0.
    - Quotient bit shifts into the LSB of the shift reg.
    - Counter increments; on the DATA_WIDTH-th iteration edge, register quotient/remainder outputs and go to DONE.
    - start is ignored in BUSY; operand changes have no effect.
  - DONE: lasts exactly one cycle; done=1, ready=1.
    - start=1 at this edge is an accept (back-to-back, same rules as IDLE).
    - Otherwise go to IDLE.
- Latency:
  - Normal divide: start accepted at edge t; busy=1 from t through t+DATA_WIDTH; done=1 in the cycle after edge t+DATA_WIDTH (8 cycles for default).
  - Divide by zero: done=1 in the cycle after edge t.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1. Otherwise div_by_zero=0 is registered with the results.
- Outputs quotient/remainder/div_by_zero change only at the completing edge; they hold between operations.
- Arithmetic invariant (divisor != 0): dividend == quotient*divisor + remainder, and remainder < divisor. Unsigned only.
- done is never asserted without a preceding accepted start. busy and done are never both 1.

Test Plan:
- Normal divide: reset, dividend=100, divisor=7, start 1 cycle -> busy for 8 cycles, then done pulse; quotient=14, remainder=2, div_by_zero=0.
- Boundary operands:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
- Divide by zero: 37/0 -> done one cycle after accept; quotient=8'hFF, remainder=37, div_by_zero=1, busy never asserted.
- Busy protection and back-to-back:
  - Pulse start with 200/3 while busy from 100/7 -> ignored; result is 14/2.
  - start held high through done -> next op accepted in the DONE cycle; 200/3 gives 66/2, done 8 cycles later.
- Reset mid-operation: deassert rst_n at iteration 4 of 100/7 -> outputs 0 immediately, no done pulse, ready=1 after release; a new 9/2 gives 4/1.
- Randomized sweep (1000 pairs, divisor incl. 0) against a reference model -> invariant holds; latency is exactly 8 (or 1 for divisor 0).

Source files
------------

// File: rtl/restoring_divider_by8.sv
// rtl/restoring_divider_by8.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
// One quotient bit per cycle via trial subtraction; results held until the next accepted start.
module restoring_divider_by8 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [CW-1:0]         r_count;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic                  r_div_by_zero;

  logic [DATA_WIDTH:0]   w_rp;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_last;
  logic                  w_accept;

  // Partial remainder stays below the divisor, so it fits in DATA_WIDTH bits between
  // iterations; the shifted value needs one extra bit, whose msb after subtraction is the borrow.
  assign w_rp         = {r_rem, r_shift[DATA_WIDTH-1]};
  assign w_trial      = w_rp - {1'b0, r_divisor};
  assign w_qbit       = ~w_trial[DATA_WIDTH];
  assign w_rem_next   = w_qbit ? w_trial[DATA_WIDTH-1:0] : w_rp[DATA_WIDTH-1:0];
  assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_qbit};
  assign w_last       = (r_count == CW'(DATA_WIDTH - 1));
  assign w_accept     = start && (r_state != S_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_divisor     <= '0;
      r_shift       <= '0;
      r_rem         <= '0;
      r_count       <= '0;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_divisor <= divisor;
            r_shift   <= dividend;
            r_rem     <= '0;
            r_count   <= '0;
            if (divisor == '0) begin
              // Divide by zero completes on the accepting edge with no iterations.
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
              r_done        <= 1'b1;
              r_ready       <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_DONE;
            end else begin
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_rem   <= w_rem_next;
          r_shift <= w_shift_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_quotient    <= w_shift_next;
            r_remainder   <= w_rem_next;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b1;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_DONE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_restoring_divider_by8.sv
// tb/tb_restoring_divider_by8.sv - directed and swept checks for restoring_divider_by8
module tb_restoring_divider_by8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_divider_by8 #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete divide: accept, count edges until done, compare against hand/model values.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input string tag);
    int         lat;
    logic       saw_busy;
    logic       overlap;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    saw_busy = busy;
    overlap  = busy && done;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) saw_busy = 1'b1;
      if (busy && done) overlap = 1'b1;
    end
    exp_q = (b == 8'd0) ? 8'hFF : a / b;
    exp_r = (b == 8'd0) ? a : a % b;
    chk({tag, "_lat"}, lat, (b == 8'd0) ? 0 : 8);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_dbz"}, div_by_zero, (b == 8'd0) ? 1 : 0);
    chk({tag, "_busy_seen"}, saw_busy, (b == 8'd0) ? 0 : 1);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_ready_at_done"}, ready, 1);
    if (b != 8'd0) begin
      chk({tag, "_inv"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk({tag, "_rem_lt"}, remainder < b, 1);
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int         n;
    logic       saw_done;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_done", done, 0);

    run_div(8'd100, 8'd7, "d100_7");
    run_div(8'd255, 8'd1, "d255_1");
    run_div(8'd5, 8'd9, "d5_9");
    run_div(8'd255, 8'd255, "d255_255");
    run_div(8'd37, 8'd0, "d37_0");

    // start pulsed with other operands while busy is ignored
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("prot_busy", busy, 1);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("prot_done", done, 1);
    chk("prot_q", quotient, 14);
    chk("prot_r", remainder, 2);
    @(posedge clk);
    #1;
    chk("prot_idle", done, 0);

    // start held high: second divide accepted in the done cycle
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_first_lat", n, 8);
    chk("b2b_first_q", quotient, 14);
    chk("b2b_first_r", remainder, 2);
    dividend = 8'd200;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_accept_done", done, 0);
    chk("b2b_hold_q", quotient, 14);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_second_lat", n, 8);
    chk("b2b_second_q", quotient, 66);
    chk("b2b_second_r", remainder, 2);
    @(posedge clk);
    #1;

    // reset during iteration 4 aborts the divide
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", saw_done, 0);
    chk("mid_rst_ready_after", ready, 1);
    run_div(8'd9, 8'd2, "d9_2");

    // swept pairs against the arithmetic reference, divisor zero included
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_div(ra, rb, "sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
